note_recorder: RTL and testbench
================================

# note_recorder

Records the 48-bit piano key vector (`pressed_key`, one bit per note, L-Do = bit 0 through 2H-Si = bit 47) as a time-stamped list of change events, then replays it. It sits directly downstream of the keyboard key decoder, in the record path, and feeds the tone generator. During playback it drives `play_key`, which the tone generator selects in place of live `pressed_key`.

## Interface
Parameters:
- `DEPTH`, 256: number of events the buffer holds (power of two).
- `ADDR_W`, 8: log2(DEPTH).
- `TICK_W`, 16: width of the per-event delta-time field.

Ports (one clock; reset is asynchronous and active-high):
- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high. Clears all state.
- `tick`, in, 1: one-cycle time-base strobe, 1 ms nominal. Consecutive ticks are at least 4 cycles apart.
- `pressed_key`, in, 48: live key vector from the key decoder.
- `rec_start`, in, 1: pulse; starts recording.
- `play_start`, in, 1: pulse; starts playback.
- `stop`, in, 1: pulse; ends recording or playback.
- `play_key`, out, 48: replayed key vector. It is 0 whenever `playing`=0.
- `recording`, out, 1: high in state REC.
- `playing`, out, 1: high in states P_FETCH, P_LOAD and P_WAIT.
- `full`, out, 1: high when `event_count`==DEPTH.
- `event_count`, out, ADDR_W+1: events stored, or the length of the last recording.

## Operation
States and transitions:
- IDLE
  - `stop` is ignored.
  - `rec_start` → REC. Sets wr_ptr=0, delta=0, prev=0.
  - else `play_start`: if event_count=0, stay in IDLE; otherwise → P_FETCH with rd_ptr=0.
- REC
  - Each cycle, if `pressed_key`≠prev and not full: write {delta, pressed_key} at wr_ptr, then wr_ptr++, prev=pressed_key, delta=tick?1:0.
  - Otherwise, on tick, delta increments and saturates at 2^TICK_W−1.
  - Because prev starts at 0, keys already held at start are recorded as an event with delta 0.
  - When full, further changes are dropped and the block stays in REC.
- REC on `stop`:
  - If prev≠0 and not full, write the release event {delta, 48'd0}.
  - Then → IDLE.
- P_FETCH: present rd_ptr to the RAM, then → P_LOAD.
- P_LOAD: wait_cnt = delta field of the read word; latch its key field. Then → P_WAIT.
- P_WAIT
  - If wait_cnt=0: play_key = latched key, rd_ptr++. Go to IDLE if rd_ptr+1 = event_count, else → P_FETCH.
  - Otherwise, on tick, wait_cnt decrements.
  - Ticks arriving during P_FETCH or P_LOAD are not counted.
- Any playback state on `stop` → IDLE, and play_key clears to 0.

Command priority and other rules:
- `stop` > `rec_start` > `play_start`.
- Start pulses outside IDLE are ignored.
- event_count equals wr_ptr and is updated on every write. It keeps its value across playback and is cleared by the next `rec_start`.
- RAM contents are not reset. Only event_count gates what is readable.

## Timing
- Reset values: play_key=0, recording=0, playing=0, full=0, event_count=0, state IDLE.
- `reset` asserted mid-operation aborts immediately to these values.
- Record: a change visible on `pressed_key` in cycle N is written at the end of cycle N. event_count reflects it in cycle N+1.
- Playback: for an event with delta 0, play_key updates 3 cycles after the `play_start` edge. A delta-d event updates 3 cycles plus d counted ticks after the previous event.
- Playback granularity is one tick. The fetch overhead is 2 cycles per event and is not compensated.
- The RAM is synchronous-read with 1 cycle latency. Reads and writes never occur in the same cycle.

## Structure
- Package `piano_pkg` holds:
  - KEY_W=48.
  - The state enum {IDLE, REC, P_FETCH, P_LOAD, P_WAIT}.
  - The event word layout: [KEY_W+TICK_W−1 : KEY_W] = delta, [KEY_W−1:0] = key.
- Sub-module `note_mem`: a simple dual-port synchronous RAM, DEPTH × (KEY_W+TICK_W) bits, with no reset.

## Test plan
- Reset mid-REC after 3 events → all outputs 0 next cycle; a following `play_start` is ignored (event_count=0).
- Sequence:
  - Stimulus: rec_start, then press bit 12 after 5 ticks, then release after 10 ticks, then stop.
  - Expected: event_count=2, words {5, bit12} and {10, 0}.
  - Playback of this recording: play_key bit12 rises 5 ticks after start (+3 cycles) and clears 10 ticks later; playing falls after the second event.
- Hold bit 0 through rec_start, then stop with no further change → events {0, bit0} and {0, 0}; event_count=2.
- With DEPTH=4, toggle keys 6 times → full=1 after the 4th write, event_count stays 4, no release event on stop.
- Idle delta of 70000 ticks → stored delta = 65535.
- `stop` during P_WAIT → play_key=0 and playing=0 next cycle; simultaneous rec_start+play_start in IDLE → REC.

Source files
------------

// File: rtl/piano_pkg.sv
// piano_pkg: shared key width and recorder state encoding for the piano record/playback path
package piano_pkg;
   localparam int KEY_W = 48;
   typedef enum logic [2:0] {IDLE, REC, P_FETCH, P_LOAD, P_WAIT} state_e;
endpackage

// File: rtl/note_mem.sv
// note_mem: simple dual-port synchronous RAM, one write port and one registered read port, no reset
module note_mem #(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8,
   parameter int WIDTH  = 64
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [WIDTH-1:0]  wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [WIDTH-1:0]  rdata_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_o <= mem_q[raddr_i];
   end
endmodule

// File: rtl/note_recorder.sv
// note_recorder: records key-vector changes as {delta ticks, keys} events and replays them on play_key
module note_recorder
   import piano_pkg::*;
#(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8,
   parameter int TICK_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic [KEY_W-1:0] pressed_key,
   input  logic             rec_start,
   input  logic             play_start,
   input  logic             stop,
   output logic [KEY_W-1:0] play_key,
   output logic             recording,
   output logic             playing,
   output logic             full,
   output logic [ADDR_W:0]  event_count
);
   localparam int WORD_W = KEY_W + TICK_W;
   localparam logic [TICK_W-1:0] DELTA_MAX = '1;
   state_e              state_q, state_d;
   logic [ADDR_W:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [TICK_W-1:0]   delta_q, delta_d, wait_q, wait_d;
   logic [KEY_W-1:0]    prev_q, prev_d, key_q, key_d, out_q, out_d;
   logic                mem_we, mem_re;
   logic [WORD_W-1:0]   wdata, rdata;
   assign full        = wr_ptr_q == (ADDR_W+1)'(DEPTH);
   assign event_count = wr_ptr_q;
   assign recording   = state_q == REC;
   assign playing     = state_q inside {P_FETCH, P_LOAD, P_WAIT};
   assign play_key    = out_q;
   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      delta_d  = delta_q;
      wait_d   = wait_q;
      prev_d   = prev_q;
      key_d    = key_q;
      out_d    = out_q;
      mem_we   = 1'b0;
      mem_re   = 1'b0;
      wdata    = {delta_q, pressed_key};
      case (state_q)
         IDLE: begin
            if (rec_start) begin
               state_d  = REC;
               wr_ptr_d = '0;
               delta_d  = '0;
               prev_d   = '0;
            end else if (play_start && wr_ptr_q != '0) begin
               state_d  = P_FETCH;
               rd_ptr_d = '0;
            end
         end
         REC: begin
            if (stop) begin
               mem_we  = prev_q != '0 && !full;
               wdata   = {delta_q, {KEY_W{1'b0}}};
               state_d = IDLE;
            end else if (pressed_key != prev_q && !full) begin
               mem_we  = 1'b1;
               prev_d  = pressed_key;
               delta_d = TICK_W'(tick);
            end else if (tick && delta_q != DELTA_MAX) begin
               delta_d = delta_q + TICK_W'(1);
            end
            wr_ptr_d = wr_ptr_q + (ADDR_W+1)'(mem_we);
         end
         P_FETCH: begin
            mem_re  = 1'b1;
            state_d = stop ? IDLE : P_LOAD;
         end
         P_LOAD: begin
            wait_d  = rdata[WORD_W-1:KEY_W];
            key_d   = rdata[KEY_W-1:0];
            state_d = stop ? IDLE : P_WAIT;
         end
         P_WAIT: begin
            if (stop) begin
               state_d = IDLE;
            end else if (wait_q == '0) begin
               out_d    = key_q;
               rd_ptr_d = rd_ptr_q + (ADDR_W+1)'(1);
               state_d  = (rd_ptr_d == wr_ptr_q) ? IDLE : P_FETCH;
            end else if (tick) begin
               wait_d = wait_q - TICK_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      // play_key must read 0 whenever not playing, including after the final event
      if (state_d == IDLE) out_d = '0;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         delta_q  <= '0;
         wait_q   <= '0;
         prev_q   <= '0;
         key_q    <= '0;
         out_q    <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         delta_q  <= delta_d;
         wait_q   <= wait_d;
         prev_q   <= prev_d;
         key_q    <= key_d;
         out_q    <= out_d;
      end
   end
   note_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .WIDTH(WORD_W)) u_mem (
      .clk     (clk),
      .we_i    (mem_we),
      .waddr_i (wr_ptr_q[ADDR_W-1:0]),
      .wdata_i (wdata),
      .re_i    (mem_re),
      .raddr_i (rd_ptr_q[ADDR_W-1:0]),
      .rdata_o (rdata)
   );
endmodule

// File: tb/tb_note_recorder.sv
// tb_note_recorder: directed checks of recording, playback timing, full and delta saturation
module tb_note_recorder;
   localparam logic [47:0] B0  = 48'd1;
   localparam logic [47:0] B5  = 48'd1 << 5;
   localparam logic [47:0] B12 = 48'd1 << 12;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset = 1'b1, tick = 1'b0, rec_start = 1'b0, play_start = 1'b0, stop = 1'b0;
   logic [47:0] pressed_key = '0, play_key;
   logic recording, playing, full;
   logic [8:0] event_count;
   logic s_tick = 1'b0, s_rec = 1'b0, s_play = 1'b0, s_stop = 1'b0;
   logic [47:0] s_key = '0, s_play_key;
   logic s_recording, s_playing, s_full;
   logic [2:0] s_count;
   int errors = 0, checks = 0;
   note_recorder u_dut (
      .clk(clk), .reset(reset), .tick(tick), .pressed_key(pressed_key),
      .rec_start(rec_start), .play_start(play_start), .stop(stop),
      .play_key(play_key), .recording(recording), .playing(playing),
      .full(full), .event_count(event_count)
   );
   note_recorder #(.DEPTH(4), .ADDR_W(2), .TICK_W(4)) u_small (
      .clk(clk), .reset(reset), .tick(s_tick), .pressed_key(s_key),
      .rec_start(s_rec), .play_start(s_play), .stop(s_stop),
      .play_key(s_play_key), .recording(s_recording), .playing(s_playing),
      .full(s_full), .event_count(s_count)
   );
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic bticks(input int n);
      repeat (n) begin
         tick = 1'b1; step(1); tick = 1'b0; step(4);
      end
   endtask
   task automatic sticks(input int n);
      repeat (n) begin
         s_tick = 1'b1; step(1); s_tick = 1'b0; step(4);
      end
   endtask
   task automatic test_reset;
      step(2);
      checks++; if (play_key !== '0) begin errors++; $display("FAIL rst_play_key got=%h want=0", play_key); end
      checks++; if ({recording, playing, full} !== 3'b000) begin errors++; $display("FAIL rst_flags got=%b want=000", {recording, playing, full}); end
      checks++; if (event_count !== 9'd0) begin errors++; $display("FAIL rst_count got=%0d want=0", event_count); end
      reset = 1'b0; step(1);
      rec_start = 1'b1; step(1); rec_start = 1'b0;
      pressed_key = 48'd1; step(1);
      pressed_key = 48'd3; step(1);
      pressed_key = 48'd0; step(1);
      checks++; if (event_count !== 9'd3 || recording !== 1'b1) begin errors++; $display("FAIL rec3 got count=%0d rec=%b want 3/1", event_count, recording); end
      #2 reset = 1'b1;
      #1;
      checks++; if (event_count !== 9'd0 || recording !== 1'b0) begin errors++; $display("FAIL async_rst got count=%0d rec=%b want 0/0", event_count, recording); end
      step(1); reset = 1'b0;
      checks++; if ({recording, playing, full} !== 3'b000 || play_key !== '0) begin errors++; $display("FAIL rst_mid got flags=%b key=%h want 000/0", {recording, playing, full}, play_key); end
      play_start = 1'b1; step(1); play_start = 1'b0;
      checks++; if (playing !== 1'b0 || event_count !== 9'd0) begin errors++; $display("FAIL play_empty got play=%b count=%0d want 0/0", playing, event_count); end
   endtask
   task automatic test_record;
      rec_start = 1'b1; step(1); rec_start = 1'b0;
      bticks(5);
      pressed_key = B12; step(1);
      checks++; if (event_count !== 9'd1) begin errors++; $display("FAIL rec_press got=%0d want=1", event_count); end
      bticks(10);
      pressed_key = '0; step(1);
      checks++; if (event_count !== 9'd2) begin errors++; $display("FAIL rec_release got=%0d want=2", event_count); end
      stop = 1'b1; step(1); stop = 1'b0;
      checks++; if (recording !== 1'b0 || event_count !== 9'd2 || full !== 1'b0) begin errors++; $display("FAIL rec_stop got rec=%b count=%0d full=%b want 0/2/0", recording, event_count, full); end
   endtask
   task automatic test_playback;
      play_start = 1'b1; step(1); play_start = 1'b0;
      checks++; if (playing !== 1'b1) begin errors++; $display("FAIL pb_start got=%b want=1", playing); end
      step(2);
      bticks(4);
      checks++; if (play_key !== '0) begin errors++; $display("FAIL pb_early got=%h want=0", play_key); end
      bticks(1);
      checks++; if (play_key !== B12) begin errors++; $display("FAIL pb_press got=%h want=%h", play_key, B12); end
      bticks(9);
      checks++; if (play_key !== B12 || playing !== 1'b1) begin errors++; $display("FAIL pb_hold got key=%h play=%b want %h/1", play_key, playing, B12); end
      bticks(1);
      checks++; if (play_key !== '0 || playing !== 1'b0 || event_count !== 9'd2) begin errors++; $display("FAIL pb_end got key=%h play=%b count=%0d want 0/0/2", play_key, playing, event_count); end
   endtask
   task automatic test_stop_play;
      play_start = 1'b1; step(1); play_start = 1'b0;
      step(2);
      bticks(5);
      checks++; if (play_key !== B12) begin errors++; $display("FAIL sp_press got=%h want=%h", play_key, B12); end
      stop = 1'b1; step(1); stop = 1'b0;
      checks++; if (play_key !== '0 || playing !== 1'b0) begin errors++; $display("FAIL sp_stop got key=%h play=%b want 0/0", play_key, playing); end
      stop = 1'b1; step(1); stop = 1'b0;
      checks++; if (recording !== 1'b0 || playing !== 1'b0 || event_count !== 9'd2) begin errors++; $display("FAIL idle_stop got rec=%b play=%b count=%0d want 0/0/2", recording, playing, event_count); end
   endtask
   task automatic test_hold;
      pressed_key = B0;
      rec_start = 1'b1; step(1); rec_start = 1'b0;
      checks++; if (event_count !== 9'd0 || recording !== 1'b1) begin errors++; $display("FAIL hold_start got count=%0d rec=%b want 0/1", event_count, recording); end
      step(1);
      checks++; if (event_count !== 9'd1) begin errors++; $display("FAIL hold_first got=%0d want=1", event_count); end
      stop = 1'b1; step(1); stop = 1'b0;
      checks++; if (event_count !== 9'd2 || recording !== 1'b0) begin errors++; $display("FAIL hold_stop got count=%0d rec=%b want 2/0", event_count, recording); end
      pressed_key = '0;
      play_start = 1'b1; step(1); play_start = 1'b0;
      step(2);
      checks++; if (play_key !== '0 || playing !== 1'b1) begin errors++; $display("FAIL hold_lat2 got key=%h play=%b want 0/1", play_key, playing); end
      step(1);
      checks++; if (play_key !== B0) begin errors++; $display("FAIL hold_lat3 got=%h want=%h", play_key, B0); end
      step(3);
      checks++; if (play_key !== '0 || playing !== 1'b0) begin errors++; $display("FAIL hold_end got key=%h play=%b want 0/0", play_key, playing); end
   endtask
   task automatic test_full;
      s_rec = 1'b1; step(1); s_rec = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         s_key = 48'(i); step(1);
         if (i == 3) begin
            checks++; if (s_full !== 1'b0 || s_count !== 3'd3) begin errors++; $display("FAIL full_3 got full=%b count=%0d want 0/3", s_full, s_count); end
         end
         if (i == 4) begin
            checks++; if (s_full !== 1'b1 || s_count !== 3'd4) begin errors++; $display("FAIL full_4 got full=%b count=%0d want 1/4", s_full, s_count); end
         end
      end
      checks++; if (s_count !== 3'd4 || s_recording !== 1'b1) begin errors++; $display("FAIL full_6 got count=%0d rec=%b want 4/1", s_count, s_recording); end
      s_stop = 1'b1; step(1); s_stop = 1'b0;
      checks++; if (s_count !== 3'd4 || s_full !== 1'b1 || s_recording !== 1'b0) begin errors++; $display("FAIL full_stop got count=%0d full=%b rec=%b want 4/1/0", s_count, s_full, s_recording); end
      s_key = '0;
      s_play = 1'b1; step(1); s_play = 1'b0;
      step(3);
      checks++; if (s_play_key !== 48'd1) begin errors++; $display("FAIL full_pb1 got=%h want=1", s_play_key); end
      step(3);
      checks++; if (s_play_key !== 48'd2) begin errors++; $display("FAIL full_pb2 got=%h want=2", s_play_key); end
      step(3);
      checks++; if (s_play_key !== 48'd3) begin errors++; $display("FAIL full_pb3 got=%h want=3", s_play_key); end
      step(3);
      checks++; if (s_play_key !== '0 || s_playing !== 1'b0) begin errors++; $display("FAIL full_pb_end got key=%h play=%b want 0/0", s_play_key, s_playing); end
   endtask
   task automatic test_saturate;
      s_rec = 1'b1; step(1); s_rec = 1'b0;
      sticks(20);
      s_key = B5; step(1);
      checks++; if (s_count !== 3'd1) begin errors++; $display("FAIL sat_press got=%0d want=1", s_count); end
      s_stop = 1'b1; step(1); s_stop = 1'b0;
      checks++; if (s_count !== 3'd2) begin errors++; $display("FAIL sat_stop got=%0d want=2", s_count); end
      s_key = '0;
      s_play = 1'b1; step(1); s_play = 1'b0;
      step(2);
      sticks(14);
      checks++; if (s_play_key !== '0 || s_playing !== 1'b1) begin errors++; $display("FAIL sat_early got key=%h play=%b want 0/1", s_play_key, s_playing); end
      s_tick = 1'b1; step(1); s_tick = 1'b0; step(1);
      checks++; if (s_play_key !== B5) begin errors++; $display("FAIL sat_fire got=%h want=%h", s_play_key, B5); end
      step(3);
      checks++; if (s_playing !== 1'b0 || s_play_key !== '0) begin errors++; $display("FAIL sat_end got play=%b key=%h want 0/0", s_playing, s_play_key); end
   endtask
   task automatic test_simultaneous;
      rec_start = 1'b1; play_start = 1'b1; step(1); rec_start = 1'b0; play_start = 1'b0;
      checks++; if (recording !== 1'b1 || playing !== 1'b0 || event_count !== 9'd0) begin errors++; $display("FAIL simul got rec=%b play=%b count=%0d want 1/0/0", recording, playing, event_count); end
      stop = 1'b1; step(1); stop = 1'b0;
      checks++; if (recording !== 1'b0) begin errors++; $display("FAIL simul_stop got=%b want=0", recording); end
   endtask
   initial begin
      test_reset;
      test_record;
      test_playback;
      test_stop_play;
      test_hold;
      test_full;
      test_saturate;
      test_simultaneous;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
